// File: rtl/simple_dual_port_bram_pkg.sv
// Shared helpers for the block RAM and the FIFO controllers built on it.
package simple_dual_port_bram_pkg;

  // Number of right shifts until the value reaches zero (784 -> 10, 1024 -> 11).
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    int unsigned n;
    v = value;
    n = 0;
    while (v != 0) begin
      v = v >> 1;
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/dff_stages.sv
// Chain of STAGE synchronously reset registers advancing every cycle; STAGE=0 is a wire.
module dff_stages #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned STAGE      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] stage_in,
  output logic [DATA_WIDTH-1:0] stage_out
);

  if (STAGE == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign stage_out      = stage_in;
  end else begin : g_regs
    logic [DATA_WIDTH-1:0] pipe_q [STAGE];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < STAGE; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= stage_in;
        for (int i = 1; i < STAGE; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign stage_out = pipe_q[STAGE-1];
  end

endmodule

// File: rtl/simple_dual_port_bram.sv
// Simple dual-port inferred BRAM: write port A, registered read-first port B, one clock.
// Define BRAM_OUT_REG_EN to add one free-running output register (read latency 2).
module simple_dual_port_bram
  import simple_dual_port_bram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DATA_DEPTH = 784,
  parameter int unsigned ADDR_WIDTH = clogb2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic                  enb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] doutb
);

`ifdef BRAM_OUT_REG_EN
  localparam int unsigned OutStages = 1;
`else
  localparam int unsigned OutStages = 0;
`endif

  localparam logic [ADDR_WIDTH:0] DepthLim = (ADDR_WIDTH+1)'(DATA_DEPTH);

  // Contents survive rst_n; only the read path is cleared.
  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  wr_ok;
  logic                  rd_in_range;

  assign wr_ok       = rst_n && ena && ({1'b0, addra} < DepthLim);
  assign rd_in_range = ({1'b0, addrb} < DepthLim);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[addra] <= dina;
  end

  // Non-blocking update of mem gives read-first behaviour on same-address collisions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (enb) begin
      rd_q <= rd_in_range ? mem[addrb] : '0;
    end
  end

  dff_stages #(
    .DATA_WIDTH (DATA_WIDTH),
    .STAGE      (OutStages)
  ) u_out_stages (
    .clk       (clk),
    .rst_n     (rst_n),
    .stage_in  (rd_q),
    .stage_out (doutb)
  );

endmodule

// File: tb/tb_simple_dual_port_bram.sv
// Randomized self-checking bench for simple_dual_port_bram against an array-based model.
module tb_simple_dual_port_bram;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 784;
  localparam int unsigned AW    = 10;
`ifdef BRAM_OUT_REG_EN
  localparam bit OutReg = 1'b1;
`else
  localparam bit OutReg = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic [AW-1:0] addra = '0;
  logic [DW-1:0] dina = '0;
  logic          enb = 1'b0;
  logic [AW-1:0] addrb = '0;
  logic [DW-1:0] doutb;
  logic          p_in = 1'b0;
  logic          p_out;

  always #5 clk = ~clk;

  simple_dual_port_bram #(
    .DATA_WIDTH (DW),
    .DATA_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .addra (addra),
    .dina  (dina),
    .enb   (enb),
    .addrb (addrb),
    .doutb (doutb)
  );

  dff_stages #(
    .DATA_WIDTH (1),
    .STAGE      (3)
  ) u_dly3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .stage_in  (p_in),
    .stage_out (p_out)
  );

  int unsigned   n_checks = 0;
  int unsigned   n_pass   = 0;
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] last_read = '0;
  logic [DW-1:0] out_stage = '0;
  logic [DW-1:0] exp_out;
  bit            pulse_hist [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // One clock: drive at negedge, update the model at posedge, compare 1 time unit later.
  task automatic step(input logic r, input logic we, input int unsigned wa,
                      input logic [DW-1:0] wd, input logic re, input int unsigned ra,
                      input logic pin, input string tag);
    @(negedge clk);
    rst_n = r;
    ena   = we;
    addra = AW'(wa);
    dina  = wd;
    enb   = re;
    addrb = AW'(ra);
    p_in  = pin;
    @(posedge clk);
    if (!r) begin
      out_stage = '0;
      last_read = '0;
      pulse_hist.delete();
    end else begin
      out_stage = last_read;
      if (re) last_read = (ra < DEPTH) ? model_mem[ra] : '0;
      if (we && wa < DEPTH) model_mem[wa] = wd;
      pulse_hist.push_back(pin);
    end
    exp_out = OutReg ? out_stage : last_read;
    #1;
    check(tag, 32'(doutb), 32'(exp_out));
    if (pulse_hist.size() >= 3) check("dly3", 32'(p_out), 32'(pulse_hist[pulse_hist.size()-3]));
    else check("dly3_fill", 32'(p_out), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, '0, 1'b1, 5, 1'b0, "reset");
    step(1'b1, 1'b0, 0, '0, 1'b1, 5, 1'b0, "read_init");
    check("zero_init", 32'(doutb), 32'd0);

    // Isolated pulse through the 3-stage delay line.
    step(1'b1, 1'b0, 0, '0, 1'b0, 0, 1'b1, "pulse");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0, '0, 1'b0, 0, 1'b0, "pulse_gap");

    step(1'b1, 1'b1, 0, 16'h1234, 1'b0, 0, 1'b0, "wr0");
    step(1'b1, 1'b1, 783, 16'hBEEF, 1'b0, 0, 1'b0, "wr783");
    step(1'b1, 1'b0, 0, '0, 1'b1, 0, 1'b0, "rd0");
    step(1'b1, 1'b0, 0, '0, 1'b1, 783, 1'b0, "rd783");
    step(1'b1, 1'b0, 0, '0, 1'b0, 0, 1'b0, "rd_drain");

    step(1'b1, 1'b1, 10, 16'h0001, 1'b0, 0, 1'b0, "col_setup");
    step(1'b1, 1'b1, 10, 16'h00FF, 1'b1, 10, 1'b0, "col_old");
    step(1'b1, 1'b0, 0, '0, 1'b1, 10, 1'b0, "col_new");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0, '0, 1'b0, 0, 1'b0, "hold");
    check("hold_value", 32'(doutb), 32'h00FF);

    step(1'b1, 1'b1, 800, 16'hAAAA, 1'b0, 0, 1'b0, "oor_wr");
    step(1'b1, 1'b0, 0, '0, 1'b1, 800, 1'b0, "oor_rd");
    step(1'b1, 1'b0, 0, '0, 1'b1, 800 - 512, 1'b0, "oor_alias");
    step(1'b1, 1'b0, 0, '0, 1'b0, 0, 1'b0, "oor_drain");
    check("oor_zero", 32'(doutb), 32'd0);

    for (int n = 0; n < DEPTH; n++)
      step(1'b1, 1'b1, n, DW'(n), n != 0, (n == 0) ? 0 : n - 1, 1'b0, "stream");

    // Mixed random traffic with occasional mid-operation resets.
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 63) != 0), 1'($urandom), $urandom_range(0, 1023),
           DW'($urandom), 1'($urandom), $urandom_range(0, 1023), 1'($urandom), "rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
